// File: rtl/aes_subbytes_pipe_if.sv
// Handshake bundle for the AES SubBytes engine: state in, substituted state out.
// The engine takes the slave view; the upstream/downstream side takes the master view.
interface aes_subbytes_pipe_if #(
  parameter int unsigned STATE_BYTES = 16
);
  logic                     mode_inv;
  logic                     in_valid;
  logic                     in_ready;
  logic [8*STATE_BYTES-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [8*STATE_BYTES-1:0] out_data;

  modport master (
    output mode_inv, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode_inv, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_subbytes_pipe.sv
// Multi-cycle AES SubBytes / InvSubBytes engine: captures a state, substitutes LANES
// bytes per cycle through parallel S-boxes, and holds the result on a valid/ready output.
module aes_subbytes_pipe #(
  parameter int unsigned STATE_BYTES = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned INV_EN      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  aes_subbytes_pipe_if.slave  bus,
  output logic                busy
);
  localparam int unsigned BEATS = STATE_BYTES / LANES;
  localparam int unsigned BW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state, state_next;
  logic [BW-1:0]            beat;
  logic [8*STATE_BYTES-1:0] work, work_next;
  logic                     mode_q;
  logic                     accept, load, finish;
  logic [7:0]               lane_in  [LANES];
  logic [7:0]               lane_out [LANES];

  // S-boxes are built from GF(2^8) inversion plus the affine map rather than stored tables.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  assign bus.in_ready  = rst_n & ~flush & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == BUSY);
  assign accept        = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (beat == BW'(BEATS - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (accept) begin
            load       = 1'b1;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      load       = 1'b0;
      finish     = 1'b0;
    end
  end

  // Lane inputs are muxed by beat so only LANES S-boxes exist regardless of state width.
  always_comb begin
    work_next = work;
    for (int unsigned l = 0; l < LANES; l++) lane_in[l] = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat == BW'(b)) begin
        for (int unsigned l = 0; l < LANES; l++) lane_in[l] = work[8*(b*LANES+l) +: 8];
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      if (mode_q) lane_out[l] = inv_sbox(lane_in[l]);
      else        lane_out[l] = fwd_sbox(lane_in[l]);
    end
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat == BW'(b)) begin
        for (int unsigned l = 0; l < LANES; l++) work_next[8*(b*LANES+l) +: 8] = lane_out[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work         <= '0;
      mode_q       <= 1'b0;
      beat         <= '0;
      bus.out_data <= '0;
    end else if (flush) begin
      beat <= '0;
    end else if (load) begin
      work   <= bus.in_data;
      mode_q <= bus.mode_inv & (INV_EN != 0);
      beat   <= '0;
    end else if (state == BUSY) begin
      work <= work_next;
      beat <= beat + BW'(1);
      if (finish) bus.out_data <= work_next;
    end
  end
endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Bench for aes_subbytes_pipe: three lane configurations driven from shared stimulus,
// checked every cycle against a table-driven model plus FIPS-197 literal vectors.
module tb_aes_subbytes_pipe;
  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         drv_valid = 1'b0, drv_mode = 1'b0, drv_oready = 1'b0;
  logic [127:0] drv_data = '0;
  int unsigned  sel = 0;
  logic         mon_ir, mon_ov, mon_busy;
  logic [127:0] mon_od;
  logic         busy4, busy1, busy16;
  int           errors = 0, checks = 0, cyc = 0, acc_cyc = 0, lat;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  int           m_phase = 0, m_cnt = 0;
  logic [127:0] m_res = '0;
  logic [127:0] m_out [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aes_subbytes_pipe_if #(.STATE_BYTES(16)) b4  ();
  aes_subbytes_pipe_if #(.STATE_BYTES(16)) b1  ();
  aes_subbytes_pipe_if #(.STATE_BYTES(16)) b16 ();

  assign b4.in_valid   = drv_valid && (sel == 0);
  assign b4.in_data    = drv_data;
  assign b4.mode_inv   = drv_mode;
  assign b4.out_ready  = (sel == 0) ? drv_oready : 1'b1;
  assign b1.in_valid   = drv_valid && (sel == 1);
  assign b1.in_data    = drv_data;
  assign b1.mode_inv   = drv_mode;
  assign b1.out_ready  = (sel == 1) ? drv_oready : 1'b1;
  assign b16.in_valid  = drv_valid && (sel == 2);
  assign b16.in_data   = drv_data;
  assign b16.mode_inv  = drv_mode;
  assign b16.out_ready = (sel == 2) ? drv_oready : 1'b1;

  aes_subbytes_pipe #(.STATE_BYTES(16), .LANES(4), .INV_EN(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b4), .busy(busy4));
  aes_subbytes_pipe #(.STATE_BYTES(16), .LANES(1), .INV_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1), .busy(busy1));
  aes_subbytes_pipe #(.STATE_BYTES(16), .LANES(16), .INV_EN(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b16), .busy(busy16));

  always_comb begin
    case (sel)
      1:       begin mon_ir = b1.in_ready;  mon_ov = b1.out_valid;  mon_od = b1.out_data;  mon_busy = busy1;  end
      2:       begin mon_ir = b16.in_ready; mon_ov = b16.out_valid; mon_od = b16.out_data; mon_busy = busy16; end
      default: begin mon_ir = b4.in_ready;  mon_ov = b4.out_valid;  mon_od = b4.out_data;  mon_busy = busy4;  end
    endcase
  end

  function automatic int beats_of(input int unsigned s);
    case (s)
      1:       return 16;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic exp_ir();
    return rst_n && !flush && (m_phase == 0 || (m_phase == 2 && drv_oready));
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_start();
    m_res   = model_sub(drv_data, drv_mode);
    m_cnt   = beats_of(sel);
    m_phase = 1;
  endtask

  // Reference: 0 idle, 1 substituting with m_cnt cycles left, 2 holding result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      for (int i = 0; i < 3; i++) m_out[i] = '0;
    end else if (flush) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (drv_valid) model_start();
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase    = 2;
            m_out[sel] = m_res;
          end
        end
        default: if (drv_oready) begin
          if (drv_valid) model_start();
          else           m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", mon_ir, exp_ir());
    check("out_valid", mon_ov, m_phase == 2);
    check("busy", mon_busy, m_phase == 1);
    check("out_data", mon_od, m_out[sel]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic m, input logic rnd);
    logic got;
    got = 1'b0;
    step();
    drv_data  = d;
    drv_mode  = m;
    drv_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rnd) drv_oready = 1'($urandom_range(0, 1));
      #1;
      if (mon_ir) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_timeout", got, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    drv_valid = 1'b0;
    drv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    drv_mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int l);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mon_ov) begin
        got = 1'b1;
        break;
      end
    end
    check("out_timeout", got, 1'b1);
    l = cyc - acc_cyc;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [2047:0] tbl;
    tbl = SBOX_TBL;
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = tbl[2047-8*i -: 8];
      inv_tab[fwd_tab[i]] = 8'(i);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", mon_ir, 1'b0);
    check("rst_out_valid", mon_ov, 1'b0);
    check("rst_out_data", mon_od, '0);
    #2 rst_n = 1'b1;

    // FIPS-197 round 1 forward, then backpressure on the held result
    send(FIPS_IN, 1'b0, 1'b0);
    wait_out(lat);
    check("t1_latency", lat, 4);
    check("t1_fwd", mon_od, FIPS_OUT);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", mon_ov, 1'b1);
      check("bp_data", mon_od, FIPS_OUT);
      check("bp_in_ready", mon_ir, 1'b0);
    end
    step();
    drv_oready = 1'b1;
    send(FIPS_OUT, 1'b1, 1'b0);
    drv_oready = 1'b0;
    @(negedge clk);
    check("release_drop", mon_ov, 1'b0);
    wait_out(lat);
    check("t2_latency", lat, 4);
    check("t2_inv", mon_od, FIPS_IN);

    step();
    drv_oready = 1'b1;
    send('0, 1'b0, 1'b0);
    drv_oready = 1'b0;
    wait_out(lat);
    check("zero_fwd", mon_od, {16{8'h63}});
    step();
    drv_oready = 1'b1;
    send({16{8'h63}}, 1'b1, 1'b0);
    drv_oready = 1'b0;
    wait_out(lat);
    check("s63_inv", mon_od, '0);

    // flush at beat 2, then flush racing a valid in IDLE
    step();
    drv_oready = 1'b1;
    repeat (2) step();
    send(FIPS_IN, 1'b0, 1'b0);
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", mon_busy, 1'b0);
    check("flush_valid", mon_ov, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("flush_hold", mon_ov, 1'b0);
    end
    step();
    flush     = 1'b1;
    drv_valid = 1'b1;
    drv_data  = FIPS_IN;
    repeat (3) begin
      @(negedge clk);
      check("flush_in_ready", mon_ir, 1'b0);
    end
    step();
    flush     = 1'b0;
    drv_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", mon_busy, 1'b0);

    // asynchronous reset in the middle of a substitution
    send(FIPS_IN, 1'b0, 1'b0);
    wait_out(lat);
    send(FIPS_OUT, 1'b1, 1'b0);
    step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", mon_ov, 1'b0);
    check("arst_busy", mon_busy, 1'b0);
    check("arst_data", mon_od, '0);
    check("arst_in_ready", mon_ir, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send(FIPS_IN, 1'b0, 1'b0);
    wait_out(lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_fwd", mon_od, FIPS_OUT);

    // lane sweep: LANES=1 and LANES=16
    for (int s = 1; s < 3; s++) begin
      step();
      drv_oready = 1'b1;
      repeat (3) step();
      sel = s;
      send(FIPS_IN, 1'b0, 1'b0);
      drv_oready = 1'b0;
      wait_out(lat);
      check("sweep_latency", lat, beats_of(s));
      check("sweep_fwd", mon_od, FIPS_OUT);
    end

    // random states, modes, valid gaps and ready stalls on every configuration
    for (int s = 0; s < 3; s++) begin
      drv_oready = 1'b1;
      repeat (20) step();
      sel = s;
      for (int k = 0; k < 334; k++) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          drv_oready = 1'($urandom_range(0, 1));
        end
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    drv_oready = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
